// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH      = 4'd0,
      S_DECODE     = 4'd1,
      S_EXEC_R     = 4'd2,
      S_EXEC_I     = 4'd3,
      S_ADDR       = 4'd4,
      S_MEM_RD     = 4'd5,
      S_MEM_WR     = 4'd6,
      S_WB_ALU     = 4'd7,
      S_WB_MEM     = 4'd8,
      S_BRANCH     = 4'd9,
      S_COPRO_REQ  = 4'd10,
      S_COPRO_WAIT = 4'd11,
      S_WB_CP      = 4'd12,
      S_TRAP       = 4'd13
   } state_e;

   localparam logic [6:0] OP_RTYPE   = 7'b0110011;
   localparam logic [6:0] OP_ITYPE   = 7'b0010011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_CP  = 2'b10;

   // All datapath controls in one bundle so reset gating is a single mux.
   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       pc_src;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       copro_valid;
   } ctrl_t;

   function automatic logic is_busy(input state_e s);
      return (s != S_FETCH) && (s != S_TRAP);
   endfunction

endpackage

// File: rtl/copro_watchdog.sv
// Cycle counter bounding how long the FSM waits for a coprocessor result.
module copro_watchdog #(
   parameter int unsigned COPRO_TIMEOUT = 255,
   parameter int unsigned CNT_W         = 16
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + 1'b1;
   end

   // Fires on the last permitted wait cycle so the FSM leaves on that edge.
   assign expired = enable && (cnt == CNT_W'(COPRO_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer with CUSTOM-0 coprocessor dispatch.
// Optional CTRL_PERF_CNT_EN adds retired-instruction and stall counters.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned COPRO_TIMEOUT = 255,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   input  logic       copro_ready,
   input  logic       copro_done,
   output logic       pc_write,
   output logic       ir_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       pc_src,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       copro_valid,
   output logic       illegal,
`ifdef CTRL_PERF_CNT_EN
   output logic [31:0] retired_cnt,
   output logic [31:0] stall_cnt,
`endif
   output logic       busy
);

   state_e state, next_state;
   ctrl_t  ctl, ctl_out;
   logic   illegal_q;
   logic   wd_clear, wd_expired;

   assign wd_clear = rst || (state == S_COPRO_REQ && copro_ready);

   copro_watchdog #(
      .COPRO_TIMEOUT(COPRO_TIMEOUT),
      .CNT_W        (CNT_W)
   ) u_wd (
      .clk    (clk),
      .clear  (wd_clear),
      .enable (state == S_COPRO_WAIT),
      .expired(wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state == S_TRAP)
            illegal_q <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      ctl        = '0;
      case (state)
         S_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = SRCB_FOUR;
            ctl.alu_op    = ALU_ADD;
            if (mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               next_state   = S_DECODE;
            end
         end
         S_DECODE: begin
            ctl.alu_src_b = SRCB_IMM;
            ctl.alu_op    = ALU_ADD;
            case (opcode)
               OP_RTYPE:          next_state = S_EXEC_R;
               OP_ITYPE:          next_state = S_EXEC_I;
               OP_LOAD, OP_STORE: next_state = S_ADDR;
               OP_BRANCH:         next_state = S_BRANCH;
               OP_CUSTOM0:        next_state = S_COPRO_REQ;
               default:           next_state = S_TRAP;
            endcase
         end
         S_EXEC_R: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_REG;
            ctl.alu_op    = ALU_FUNCT;
            next_state    = S_WB_ALU;
         end
         S_EXEC_I: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            ctl.alu_op    = ALU_FUNCT;
            next_state    = S_WB_ALU;
         end
         S_ADDR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            ctl.alu_op    = ALU_ADD;
            next_state    = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            ctl.mem_read = 1'b1;
            ctl.i_or_d   = 1'b1;
            if (mem_ready) next_state = S_WB_MEM;
         end
         S_MEM_WR: begin
            ctl.mem_write = 1'b1;
            ctl.i_or_d    = 1'b1;
            if (mem_ready) next_state = S_FETCH;
         end
         S_WB_ALU: begin
            ctl.reg_write = 1'b1;
            ctl.wb_sel    = WB_ALU;
            next_state    = S_FETCH;
         end
         S_WB_MEM: begin
            ctl.reg_write = 1'b1;
            ctl.wb_sel    = WB_MEM;
            next_state    = S_FETCH;
         end
         S_BRANCH: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_REG;
            ctl.alu_op    = ALU_SUB;
            ctl.pc_src    = 1'b1;
            ctl.pc_write  = zero;
            next_state    = S_FETCH;
         end
         S_COPRO_REQ: begin
            ctl.copro_valid = 1'b1;
            if (copro_ready) next_state = S_COPRO_WAIT;
         end
         S_COPRO_WAIT: begin
            // A result on the final watchdog cycle still completes normally.
            if (copro_done)      next_state = S_WB_CP;
            else if (wd_expired) next_state = S_TRAP;
         end
         S_WB_CP: begin
            ctl.reg_write = 1'b1;
            ctl.wb_sel    = WB_CP;
            next_state    = S_FETCH;
         end
         S_TRAP:  next_state = S_TRAP;
         default: next_state = S_FETCH;
      endcase
   end

   // Reset gates every control combinationally so an abandoned access stops at once.
   assign ctl_out = rst ? '0 : ctl;

   assign pc_write    = ctl_out.pc_write;
   assign ir_write    = ctl_out.ir_write;
   assign i_or_d      = ctl_out.i_or_d;
   assign mem_read    = ctl_out.mem_read;
   assign mem_write   = ctl_out.mem_write;
   assign alu_src_a   = ctl_out.alu_src_a;
   assign alu_src_b   = ctl_out.alu_src_b;
   assign alu_op      = ctl_out.alu_op;
   assign pc_src      = ctl_out.pc_src;
   assign reg_write   = ctl_out.reg_write;
   assign wb_sel      = ctl_out.wb_sel;
   assign copro_valid = ctl_out.copro_valid;
   assign illegal     = illegal_q;
   assign busy        = !rst && is_busy(state);

`ifdef CTRL_PERF_CNT_EN
   logic stalled;

   always_comb begin
      case (state)
         S_FETCH, S_MEM_RD, S_MEM_WR: stalled = !mem_ready;
         S_COPRO_REQ:                 stalled = !copro_ready;
         S_COPRO_WAIT:                stalled = !copro_done;
         default:                     stalled = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         retired_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (next_state == S_FETCH && state != S_FETCH && state != S_TRAP)
            retired_cnt <= retired_cnt + 32'd1;
         if (stalled)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
